// File: rtl/maj_pkg.sv
// Shared constants for the 53-input majority voter plus a reference popcount.
// Pure declarations: no logic, no latency, no flow control.
package maj_pkg;

  localparam int N     = 53;
  localparam int THR   = 27;
  localparam int CNT_W = 6;
  localparam int BIAS  = (1 << CNT_W) - THR;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/full_adder.sv
// 3:2 counter cell used to build the carry-save popcount tree.
// Purely combinational; no state, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/top.sv
// 53-input majority voter: carry-save popcount tree, threshold taken as a bias carry-out.
// y0 is combinational; y0_q/cnt_q lag one clk; no backpressure, samples every clk.
module top import maj_pkg::*; #(
  parameter int N   = maj_pkg::N,
  parameter int THR = maj_pkg::THR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,
  input  logic x10, x11, x12, x13, x14, x15, x16, x17, x18, x19,
  input  logic x20, x21, x22, x23, x24, x25, x26, x27, x28, x29,
  input  logic x30, x31, x32, x33, x34, x35, x36, x37, x38, x39,
  input  logic x40, x41, x42, x43, x44, x45, x46, x47, x48, x49,
  input  logic x50, x51, x52,
  output logic y0,
  output logic y0_q,
  output logic [CNT_W-1:0] cnt_q
);

  localparam logic [CNT_W:0] BIAS_C = (CNT_W+1)'((1 << CNT_W) - THR);

  logic [N-1:0]     x_vec;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] unused_bias_low;
  logic             y0_d;
  logic [CNT_W-1:0] cnt_d;

  assign x_vec = {x52, x51, x50, x49, x48, x47, x46, x45, x44, x43,
                  x42, x41, x40, x39, x38, x37, x36, x35, x34, x33,
                  x32, x31, x30, x29, x28, x27, x26, x25, x24, x23,
                  x22, x21, x20, x19, x18, x17, x16, x15, x14, x13,
                  x12, x11, x10, x9,  x8,  x7,  x6,  x5,  x4,  x3,
                  x2,  x1,  x0};

  // Wallace levels: 53 -> 36 -> 24 -> 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 operands
  logic [CNT_W-1:0] lvl0 [N];
  logic [CNT_W-1:0] lvl1 [36];
  logic [CNT_W-1:0] lvl2 [24];
  logic [CNT_W-1:0] lvl3 [16];
  logic [CNT_W-1:0] lvl4 [11];
  logic [CNT_W-1:0] lvl5 [8];
  logic [CNT_W-1:0] lvl6 [6];
  logic [CNT_W-1:0] lvl7 [4];
  logic [CNT_W-1:0] lvl8 [3];
  logic [CNT_W-1:0] lvl9 [2];
  logic [CNT_W-1:0] cy0 [17];
  logic [CNT_W-1:0] cy1 [12];
  logic [CNT_W-1:0] cy2 [8];
  logic [CNT_W-1:0] cy3 [5];
  logic [CNT_W-1:0] cy4 [3];
  logic [CNT_W-1:0] cy5 [2];
  logic [CNT_W-1:0] cy6 [2];
  logic [CNT_W-1:0] cy7 [1];
  logic [CNT_W-1:0] cy8 [1];
  // Every partial sum stays <= 53, so the carry out of the top bit is always zero.
  logic [50:0]      unused_top_co;

  for (genvar k = 0; k < N; k++) begin : g_in
    assign lvl0[k] = {{(CNT_W-1){1'b0}}, x_vec[k]};
  end

  for (genvar i = 0; i < 17; i++) begin : g_l0
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl0[3*i][b]), .b(lvl0[3*i+1][b]), .ci(lvl0[3*i+2][b]), .s(lvl1[2*i][b]), .co(cy0[i][b]));
    end
    assign lvl1[2*i+1]       = {cy0[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[i]  = cy0[i][CNT_W-1];
  end
  assign lvl1[34] = lvl0[51];
  assign lvl1[35] = lvl0[52];

  for (genvar i = 0; i < 12; i++) begin : g_l1
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl1[3*i][b]), .b(lvl1[3*i+1][b]), .ci(lvl1[3*i+2][b]), .s(lvl2[2*i][b]), .co(cy1[i][b]));
    end
    assign lvl2[2*i+1]         = {cy1[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[17+i] = cy1[i][CNT_W-1];
  end

  for (genvar i = 0; i < 8; i++) begin : g_l2
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl2[3*i][b]), .b(lvl2[3*i+1][b]), .ci(lvl2[3*i+2][b]), .s(lvl3[2*i][b]), .co(cy2[i][b]));
    end
    assign lvl3[2*i+1]         = {cy2[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[29+i] = cy2[i][CNT_W-1];
  end

  for (genvar i = 0; i < 5; i++) begin : g_l3
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl3[3*i][b]), .b(lvl3[3*i+1][b]), .ci(lvl3[3*i+2][b]), .s(lvl4[2*i][b]), .co(cy3[i][b]));
    end
    assign lvl4[2*i+1]         = {cy3[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[37+i] = cy3[i][CNT_W-1];
  end
  assign lvl4[10] = lvl3[15];

  for (genvar i = 0; i < 3; i++) begin : g_l4
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl4[3*i][b]), .b(lvl4[3*i+1][b]), .ci(lvl4[3*i+2][b]), .s(lvl5[2*i][b]), .co(cy4[i][b]));
    end
    assign lvl5[2*i+1]         = {cy4[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[42+i] = cy4[i][CNT_W-1];
  end
  assign lvl5[6] = lvl4[9];
  assign lvl5[7] = lvl4[10];

  for (genvar i = 0; i < 2; i++) begin : g_l5
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl5[3*i][b]), .b(lvl5[3*i+1][b]), .ci(lvl5[3*i+2][b]), .s(lvl6[2*i][b]), .co(cy5[i][b]));
    end
    assign lvl6[2*i+1]         = {cy5[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[45+i] = cy5[i][CNT_W-1];
  end
  assign lvl6[4] = lvl5[6];
  assign lvl6[5] = lvl5[7];

  for (genvar i = 0; i < 2; i++) begin : g_l6
    for (genvar b = 0; b < CNT_W; b++) begin : g_b
      full_adder u_fa (.a(lvl6[3*i][b]), .b(lvl6[3*i+1][b]), .ci(lvl6[3*i+2][b]), .s(lvl7[2*i][b]), .co(cy6[i][b]));
    end
    assign lvl7[2*i+1]         = {cy6[i][CNT_W-2:0], 1'b0};
    assign unused_top_co[47+i] = cy6[i][CNT_W-1];
  end

  for (genvar b = 0; b < CNT_W; b++) begin : g_l7
    full_adder u_fa (.a(lvl7[0][b]), .b(lvl7[1][b]), .ci(lvl7[2][b]), .s(lvl8[0][b]), .co(cy7[0][b]));
  end
  assign lvl8[1]           = {cy7[0][CNT_W-2:0], 1'b0};
  assign unused_top_co[49] = cy7[0][CNT_W-1];
  assign lvl8[2]           = lvl7[3];

  for (genvar b = 0; b < CNT_W; b++) begin : g_l8
    full_adder u_fa (.a(lvl8[0][b]), .b(lvl8[1][b]), .ci(lvl8[2][b]), .s(lvl9[0][b]), .co(cy8[0][b]));
  end
  assign lvl9[1]           = {cy8[0][CNT_W-2:0], 1'b0};
  assign unused_top_co[50] = cy8[0][CNT_W-1];

  assign cnt = lvl9[0] + lvl9[1];

  // count >= THR exactly when count + (64 - THR) carries into bit 6
  assign {y0, unused_bias_low} = {1'b0, cnt} + BIAS_C;

  always_comb begin
    y0_d  = y0;
    cnt_d = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      y0_q  <= y0_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed and weighted-random checks of the 53-input majority voter and its registered outputs.
module tb_top;
  import maj_pkg::*;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n;
  logic [52:0] x;
  logic        y0;
  logic        y0_q;
  logic [5:0]  cnt_q;

  int checks = 0;
  int errors = 0;

  always #5 if (clk_run) clk = ~clk;

  top dut (
    .clk(clk), .rst_n(rst_n),
    .x0(x[0]),   .x1(x[1]),   .x2(x[2]),   .x3(x[3]),   .x4(x[4]),   .x5(x[5]),   .x6(x[6]),   .x7(x[7]),
    .x8(x[8]),   .x9(x[9]),   .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
    .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]), .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
    .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
    .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
    .x40(x[40]), .x41(x[41]), .x42(x[42]), .x43(x[43]), .x44(x[44]), .x45(x[45]), .x46(x[46]), .x47(x[47]),
    .x48(x[48]), .x49(x[49]), .x50(x[50]), .x51(x[51]), .x52(x[52]),
    .y0(y0), .y0_q(y0_q), .cnt_q(cnt_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds a vector with exactly k ones, k weighted toward the 25..28 threshold band.
  task automatic gen_vec(output logic [52:0] v, output int k);
    int n;
    int p;
    k = ($urandom_range(3) != 0) ? 25 + int'($urandom_range(3)) : int'($urandom_range(53));
    v = '0;
    n = 0;
    while (n < k) begin
      p = int'($urandom_range(52));
      if (!v[p]) begin
        v[p] = 1'b1;
        n++;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [52:0] v;
    int          k;

    rst_n = 1'b0;
    x     = '0;
    #2;
    check("rst_y0_q", y0_q, 0);
    check("rst_cnt_q", cnt_q, 0);
    check("rst_y0", y0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("zero_y0", y0, 0);
    check("zero_y0_q", y0_q, 0);
    check("zero_cnt_q", cnt_q, 0);

    x = '0;
    for (int i = 0; i < 26; i++) x[i] = 1'b1;
    #1;
    check("ones26_y0", y0, 0);
    tick();
    check("ones26_cnt_q", cnt_q, 26);
    check("ones26_y0_q", y0_q, 0);
    x[26] = 1'b1;
    #1;
    check("ones27_y0", y0, 1);
    tick();
    check("ones27_y0_q", y0_q, 1);
    check("ones27_cnt_q", cnt_q, 27);

    x = '0;
    for (int i = 26; i < 53; i++) x[i] = 1'b1;
    #1;
    check("high27_y0", y0, 1);
    x[52] = 1'b0;
    #1;
    check("high26_y0", y0, 0);
    tick();
    check("high26_cnt_q", cnt_q, 26);
    check("high26_y0_q", y0_q, 0);

    x = '0;
    for (int i = 0; i < 53; i += 2) x[i] = 1'b1;
    #1;
    check("even27_y0", y0, 1);
    tick();
    check("even27_cnt_q", cnt_q, 27);
    x = ~x;
    #1;
    check("odd26_y0", y0, 0);
    tick();
    check("odd26_cnt_q", cnt_q, 26);

    x = '1;
    #1;
    check("all_y0", y0, 1);
    tick();
    check("all_cnt_q", cnt_q, 53);
    check("all_y0_q", y0_q, 1);

    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_y0_q", y0_q, 0);
    check("midrst_cnt_q", cnt_q, 0);
    check("midrst_y0", y0, 1);
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_y0_q", y0_q, 1);
    check("postrst_cnt_q", cnt_q, 53);

    @(negedge clk);
    clk_run = 1'b0;
    for (int n = 0; n < 1_000_000; n++) begin
      gen_vec(v, k);
      x = v;
      #1;
      check("rand_y0", y0, (k >= 27) ? 1 : 0);
    end
    clk_run = 1'b1;

    tick();
    for (int n = 0; n < 20; n++) begin
      gen_vec(v, k);
      x = v;
      tick();
      check("rand_cnt_q", cnt_q, 32'(popcount(v)));
      check("rand_y0_q", y0_q, (k >= 27) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter N, default 53: number of voter inputs; fixed at 53 for this block.
REQ-002 Parameter THR, default 27: minimum ones count for y0=1, equal to (N+1)/2.
REQ-003 clk  input  1: clock; used only by the registered outputs.
REQ-004 rst_n  input  1: reset; one clock; asynchronous, active-low.
REQ-005 x0 .. x52  input  1 each: 53 scalar voter inputs, no vector port.
REQ-006 y0  output  1: combinational majority of x0..x52.
REQ-007 y0_q  output  1: y0 registered on rising clk.
REQ-008 cnt_q  output  6: registered ones count of x0..x52, range 0..53.

Function
REQ-009 y0 SHALL be 1 when popcount(x0..x52) >= 27, else 0.
REQ-010 y0 SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst_n.
REQ-011 The popcount SHALL be computed as a 6-bit unsigned sum with no overflow (maximum 53 < 64).
REQ-012 Boundary behaviour:
- 26 ones -> y0=0
- 27 ones -> y0=1
- all zeros -> y0=0
- all ones -> y0=1
REQ-013 Symmetry: y0 SHALL depend only on the number of ones, not on which inputs are set.
REQ-014 Registered outputs:
- On each rising clk with rst_n=1: y0_q <= y0 and cnt_q <= popcount.
- Latency is 1 cycle.
REQ-015 X or Z on any input SHALL not be masked; the output MAY propagate X.

Reset
REQ-016 rst_n=0 SHALL asynchronously force y0_q=0 and cnt_q=0, independent of clk.
REQ-017 Reset SHALL NOT affect y0, which keeps tracking the inputs during reset.
REQ-018 After rst_n deasserts, the first rising clk SHALL load the current y0 and popcount.
REQ-019 If reset is asserted mid-operation, registered state SHALL be discarded with no recovery sequence.

Structure
REQ-020 Majority logic SHALL be a compressor tree (carry-save reduction), not a behavioural loop compare:
- bias decomposition: add constant 64-27=37 to the count and take carry-out bit 6, or an equivalent folded threshold.
REQ-021 A shared package maj_pkg SHALL hold:
- constants N=53, THR=27, CNT_W=6, BIAS=37;
- the popcount reference function, for benches.
REQ-022 One sub-module, full_adder (3 inputs -> sum, carry; carry is maj3), SHALL be instantiated repeatedly to build the tree.
REQ-023 The combinational path x -> y0 SHALL contain no latches and no feedback.

Verification
REQ-024 All inputs 0, rst_n=1, one clk -> y0=0, y0_q=0, cnt_q=0.
REQ-025 Exactly 26 ones (x0..x25=1) -> y0=0; then set x26=1 (27 ones) -> y0=1 within the same delta, and y0_q=1, cnt_q=27 after the next clk.
REQ-026 27 ones scattered (x52..x26=1, rest 0) -> y0=1; clear x52 -> y0=0.
REQ-027 All 53 ones -> y0=1, cnt_q=53 after one clk.
REQ-028 With y0_q=1, assert rst_n=0 between clock edges:
- y0_q=0 and cnt_q=0 immediately;
- y0 stays 1;
- deassert, one clk -> y0_q=1.
REQ-029 Random regression of at least 1e6 vectors, weighted toward counts 25..28 -> y0 equals (popcount >= 27) on every vector, checked 1 ns after each input change.
